lcd_spi_init_seq: RTL and testbench
===================================

# lcd_spi_init_seq

Table-driven power-up sequencer for the MI_LCD panel's 3-wire SPI configuration port: it walks a command table, serialises 9-bit command/data words onto the panel's SPI pins, and inserts programmed delays. It sits in the top level beside the clocked-video output and drives the LCD chip-select, serial clock and data pins. `disp_ready` gates the panel's video enable until configuration is complete. Its table is an external synchronous ROM, so panel variants need only a new ROM image.

## Interface
- `CLK_DIV`, 25: clk_50 cycles per SCLK half-period. Must be ≥1; the default gives 1 MHz at 50 MHz.
- `DELAY_UNIT`, 50000: clk_50 cycles per delay tick (1 ms at 50 MHz).
- `ADDR_W`, 6: ROM address width.
- `NUM_WORDS`, 64: table length. Must be ≤2^ADDR_W.
- `clk_50`  in  1  sole clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `start`  in  1  single-cycle re-initialisation request.
- `rom_addr`  out  ADDR_W  table address.
- `rom_data`  in  11  table entry, valid one cycle after `rom_addr`. Bits [10:9] = op, bits [8:0] = payload.
- `lcd_cs`  out  1  chip select, active low.
- `lcd_sclk`  out  1  serial clock, idle low.
- `lcd_sdi`  out  1  serial data.
- `busy`  out  1  sequence in progress.
- `disp_ready`  out  1  sequence finished; the panel may be enabled.
- `word_cnt`  out  8  words shifted since the last start. Saturates at 255.

## Operation
- Table ops:
  - 00 = command word: 9-bit word {0, payload[7:0]}.
  - 01 = data word: 9-bit word {1, payload[7:0]}.
  - 10 = delay of payload[7:0] × DELAY_UNIT cycles.
  - 11 = end of table.
- States and transitions:
  - IDLE: leaves on the first clock with reset_n=1 (auto-start), or on `start` when disp_ready=1.
  - FETCH: presents `rom_addr`.
  - DECODE: reads `rom_data` and branches:
    - op 00/01 → SHIFT.
    - op 10 → DELAY.
    - op 11 → DONE.
  - SHIFT: 9 bits, MSB (the D/C bit) first.
  - GAP: CS high for CLK_DIV cycles, then NEXT.
  - DELAY: counts down, then NEXT.
  - NEXT: if rom_addr == NUM_WORDS-1 → DONE; otherwise rom_addr+1 → FETCH.
  - DONE: sets disp_ready=1 and busy=0.
- SPI is mode 0:
  - On entering SHIFT, `lcd_cs` falls and `lcd_sdi` = bit 8, registered in the same cycle.
  - `lcd_sclk` rises CLK_DIV cycles later; the slave samples on this edge.
  - `lcd_sclk` falls after another CLK_DIV cycles, and `lcd_sdi` advances to the next bit in that cycle.
  - After the 9th falling edge, `lcd_cs` returns high in the same cycle and the block enters GAP.
  - `word_cnt` increments on that cycle.
- A delay of 0 passes straight to NEXT with no wait.
- `start` while busy=1 is ignored (not queued).
- `start` in DONE: clears disp_ready, word_cnt and rom_addr, then enters FETCH on the next cycle.
- `lcd_sdi` holds 0 whenever `lcd_cs`=1.

## Timing
- Reset values (applied on any clock with reset_n=0, including mid-word or mid-delay):
  - `lcd_cs`=1, `lcd_sclk`=0, `lcd_sdi`=0.
  - busy=0, disp_ready=0, rom_addr=0, word_cnt=0, state IDLE.
- First clock after reset release: busy=1, state FETCH. No command is issued during reset.
- One data word costs 2 (FETCH+DECODE) + 18·CLK_DIV (SHIFT) + CLK_DIV (GAP) + 1 (NEXT) cycles. With CLK_DIV=25 this is 478 cycles.
- A delay entry costs 2 + N·DELAY_UNIT + 1 cycles.
- An end entry reaches DONE 2 cycles after FETCH.
- Within a word:
  - `lcd_sclk` has exactly 9 rising edges.
  - `lcd_cs` low time is exactly 18·CLK_DIV cycles.
  - `lcd_sdi` is stable for ≥CLK_DIV cycles around each rising edge.
- Address boundary: rom_addr never exceeds NUM_WORDS-1 and never wraps to 0 mid-sequence.

## Test plan
- Cmd/data sequence:
  - Stimulus: reset_n low for 4 cycles, CLK_DIV=2, table {00/0x11, 01/0xA5, 11}.
  - Required response: the bench SPI monitor captures 0x011 then 0x1A5.
  - word_cnt=2, disp_ready rises 2 cycles after the end fetch.
  - Each CS low time is 36 cycles with 9 SCLK rising edges.
- Delay entries:
  - Stimulus: DELAY_UNIT=10, table {10/3, 00/0x29, 10/0, 11}.
  - Required response: the first CS fall occurs exactly 35 cycles after the first FETCH.
  - The zero delay adds only 3 cycles.
- Mid-word reset:
  - Stimulus: reset_n=0 asserted during the 5th bit.
  - Required response: next cycle `lcd_cs`=1, `lcd_sclk`=0, busy=0.
  - After release the sequence restarts at address 0 and the monitor sees a full word.
- start handling:
  - Stimulus: `start` pulsed while busy=1.
  - Required response: no effect, and the word count is unchanged at DONE.
  - Stimulus: `start` pulsed in DONE.
  - Required response: disp_ready drops the next cycle and the identical word stream repeats.
- No end op:
  - Stimulus: NUM_WORDS=4, table of four 00-ops.
  - Required response: exactly 4 words are sent, disp_ready=1, and rom_addr stays at 3.
- Idle levels:
  - Stimulus: gap periods between words.
  - Required response: `lcd_sdi`=0 and `lcd_sclk`=0 whenever `lcd_cs`=1.
  - Each gap is ≥CLK_DIV cycles.

Source files
------------

// File: rtl/lcd_spi_init_seq_if.sv
// Bus between the LCD init sequencer and its surroundings: table ROM port,
// 3-wire SPI pins, restart request and status.
interface lcd_spi_init_seq_if #(
  parameter int ADDR_W = 6
);
  logic              start;
  logic [ADDR_W-1:0] rom_addr;
  logic [10:0]       rom_data;
  logic              lcd_cs;
  logic              lcd_sclk;
  logic              lcd_sdi;
  logic              busy;
  logic              disp_ready;
  logic [7:0]        word_cnt;

  modport master (
    input  start, rom_data,
    output rom_addr, lcd_cs, lcd_sclk, lcd_sdi, busy, disp_ready, word_cnt
  );

  modport slave (
    output start, rom_data,
    input  rom_addr, lcd_cs, lcd_sclk, lcd_sdi, busy, disp_ready, word_cnt
  );
endinterface

// File: rtl/lcd_spi_init_seq.sv
// Table-driven power-up sequencer: walks an external ROM of command/data/delay
// entries and shifts 9-bit words out on the panel's 3-wire mode-0 SPI port.
module lcd_spi_init_seq #(
  parameter int CLK_DIV    = 25,
  parameter int DELAY_UNIT = 50000,
  parameter int ADDR_W     = 6,
  parameter int NUM_WORDS  = 64
) (
  input  logic                clk_50,
  input  logic                reset_n,
  lcd_spi_init_seq_if.master  bus
);

  localparam int                DIV_W     = $clog2(CLK_DIV + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam int                TICK_W    = $clog2(DELAY_UNIT + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DELAY_UNIT - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    OP_CMD   = 2'b00,
    OP_DATA  = 2'b01,
    OP_DELAY = 2'b10,
    OP_END   = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, SHIFT, GAP, DELAY, NEXT, DONE
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   addr;
  logic [DIV_W-1:0]    div_cnt;
  logic [TICK_W-1:0]   tick_cnt;
  logic [7:0]          ticks;
  logic [3:0]          bit_cnt;
  logic [7:0]          shreg;
  logic                cs;
  logic                sclk;
  logic                sdi;
  logic                busy;
  logic                ready;
  logic [7:0]          words;

  op_t                 op;
  logic [7:0]          payload;
  logic                unused_payload_msb;

  assign op                 = op_t'(bus.rom_data[10:9]);
  assign payload            = bus.rom_data[7:0];
  assign unused_payload_msb = bus.rom_data[8];

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      state <= IDLE;
      addr  <= '0;
      cs    <= 1'b1;
      sclk  <= 1'b0;
      sdi   <= 1'b0;
      busy  <= 1'b0;
      ready <= 1'b0;
      words <= '0;
    end else begin
      case (state)
        IDLE: begin
          busy  <= 1'b1;
          state <= FETCH;
        end
        // ROM registers the entry at the end of FETCH; it is valid in DECODE.
        FETCH: state <= DECODE;
        DECODE: begin
          case (op)
            OP_CMD, OP_DATA: begin
              shreg   <= payload;
              sdi     <= (op == OP_DATA);
              cs      <= 1'b0;
              div_cnt <= '0;
              bit_cnt <= '0;
              state   <= SHIFT;
            end
            OP_DELAY: begin
              if (payload == 8'd0) begin
                state <= NEXT;
              end else begin
                ticks    <= payload;
                tick_cnt <= '0;
                state    <= DELAY;
              end
            end
            default: begin
              busy  <= 1'b0;
              ready <= 1'b1;
              state <= DONE;
            end
          endcase
        end
        // Each half SCLK period is CLK_DIV cycles; data advances on the falling edge.
        SHIFT: begin
          if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (!sclk) begin
              sclk <= 1'b1;
            end else begin
              sclk <= 1'b0;
              if (bit_cnt == 4'd8) begin
                cs    <= 1'b1;
                sdi   <= 1'b0;
                words <= sat_inc(words);
                state <= GAP;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
                sdi     <= shreg[7];
                shreg   <= {shreg[6:0], 1'b0};
              end
            end
          end
        end
        GAP: begin
          if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            state   <= NEXT;
          end
        end
        DELAY: begin
          if (tick_cnt != TICK_LAST) begin
            tick_cnt <= tick_cnt + 1'b1;
          end else begin
            tick_cnt <= '0;
            if (ticks == 8'd1) state <= NEXT;
            else               ticks <= ticks - 8'd1;
          end
        end
        // A table without an end entry stops at its last slot, never wrapping.
        NEXT: begin
          if (addr == ADDR_LAST) begin
            busy  <= 1'b0;
            ready <= 1'b1;
            state <= DONE;
          end else begin
            addr  <= addr + 1'b1;
            state <= FETCH;
          end
        end
        DONE: begin
          if (bus.start) begin
            ready <= 1'b0;
            words <= '0;
            addr  <= '0;
            busy  <= 1'b1;
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rom_addr   = addr;
  assign bus.lcd_cs     = cs;
  assign bus.lcd_sclk   = sclk;
  assign bus.lcd_sdi    = sdi;
  assign bus.busy       = busy;
  assign bus.disp_ready = ready;
  assign bus.word_cnt   = words;

endmodule

// File: tb/tb_lcd_spi_init_seq.sv
// Directed bench for lcd_spi_init_seq: ROM model, SPI monitor and a linear
// sequence of steps with hand-computed cycle counts (CLK_DIV=2, DELAY_UNIT=10).
module tb_lcd_spi_init_seq;
  localparam int CLK_DIV    = 2;
  localparam int DELAY_UNIT = 10;
  localparam int ADDR_W     = 6;
  localparam int NUM_WORDS  = 4;

  logic clk_50 = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk_50 = ~clk_50;

  lcd_spi_init_seq_if #(.ADDR_W(ADDR_W)) bus ();

  lcd_spi_init_seq #(
    .CLK_DIV(CLK_DIV), .DELAY_UNIT(DELAY_UNIT), .ADDR_W(ADDR_W), .NUM_WORDS(NUM_WORDS)
  ) dut (
    .clk_50(clk_50), .reset_n(reset_n), .bus(bus)
  );

  logic [10:0] rom [0:63];
  always @(posedge clk_50) bus.rom_data <= rom[bus.rom_addr];

  // SPI monitor, sampling on the falling clock edge
  logic       mon_clr;
  logic [8:0] mon_sh;
  logic [8:0] mon_word [0:7];
  int         mon_low  [0:7];
  int         mon_rise [0:7];
  int         mon_n, low_cnt, rise_cnt, high_run, gap_min, idle_bad;
  logic       prev_cs, prev_sclk;

  always @(negedge clk_50) begin
    if (mon_clr) begin
      mon_n <= 0; low_cnt <= 0; rise_cnt <= 0; high_run <= 0;
      gap_min <= 1000; idle_bad <= 0; prev_cs <= 1'b1; prev_sclk <= 1'b0; mon_sh <= '0;
    end else begin
      prev_cs   <= bus.lcd_cs;
      prev_sclk <= bus.lcd_sclk;
      if (!bus.lcd_cs) begin
        low_cnt <= low_cnt + 1;
        if (bus.lcd_sclk && !prev_sclk) begin
          rise_cnt <= rise_cnt + 1;
          mon_sh   <= {mon_sh[7:0], bus.lcd_sdi};
        end
        if (prev_cs && mon_n > 0 && high_run < gap_min) gap_min <= high_run;
        high_run <= 0;
      end else begin
        high_run <= high_run + 1;
        if (bus.lcd_sdi || bus.lcd_sclk) idle_bad <= idle_bad + 1;
        if (!prev_cs) begin
          if (reset_n && mon_n < 8) begin
            mon_word[mon_n] <= mon_sh;
            mon_low[mon_n]  <= low_cnt;
            mon_rise[mon_n] <= rise_cnt;
            mon_n           <= mon_n + 1;
          end
          low_cnt <= 0; rise_cnt <= 0; mon_sh <= '0;
        end
      end
    end
  end

  int n_err = 0;
  int n_chk = 0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk_50);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input int max, output int n);
    n = 0;
    while (!bus.disp_ready && n < max) begin
      tick(1);
      n++;
    end
  endtask

  task automatic wait_cs_low(input int max, output int n);
    n = 0;
    while (bus.lcd_cs && n < max) begin
      tick(1);
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    for (int i = 0; i < 64; i++) rom[i] = 11'h600;
    bus.start = 1'b0;
    reset_n   = 1'b0;
    mon_clr   = 1'b1;
    rom[0] = 11'h011;
    rom[1] = 11'h2A5;
    rom[2] = 11'h600;
    tick(4);

    chk("reset_cs", bus.lcd_cs, 1);
    chk("reset_sclk", bus.lcd_sclk, 0);
    chk("reset_sdi", bus.lcd_sdi, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_ready", bus.disp_ready, 0);
    chk("reset_addr", bus.rom_addr, 0);
    chk("reset_wcnt", bus.word_cnt, 0);

    // cmd/data sequence; FETCH is the first cycle after release
    reset_n = 1'b1;
    mon_clr = 1'b0;
    tick(1);
    chk("first_busy", bus.busy, 1);
    chk("first_addr", bus.rom_addr, 0);
    tick(2);
    chk("cs_fall", bus.lcd_cs, 0);
    chk("first_bit", bus.lcd_sdi, 0);
    tick(81);
    chk("ready_early", bus.disp_ready, 0);
    tick(1);
    chk("ready_at_84", bus.disp_ready, 1);
    chk("done_busy", bus.busy, 0);
    chk("done_wcnt", bus.word_cnt, 2);
    chk("done_addr", bus.rom_addr, 2);
    chk("mon_count", mon_n, 2);
    chk("word0", mon_word[0], 9'h011);
    chk("word1", mon_word[1], 9'h1A5);
    chk("low0", mon_low[0], 36);
    chk("low1", mon_low[1], 36);
    chk("rise0", mon_rise[0], 9);
    chk("rise1", mon_rise[1], 9);
    chk("gap_min", gap_min >= CLK_DIV, 1);
    chk("idle_levels", idle_bad, 0);

    // start in DONE restarts; start while busy is ignored
    mon_clr = 1'b1;
    tick(1);
    mon_clr = 1'b0;
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    chk("restart_ready", bus.disp_ready, 0);
    chk("restart_busy", bus.busy, 1);
    chk("restart_wcnt", bus.word_cnt, 0);
    chk("restart_addr", bus.rom_addr, 0);
    tick(20);
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    tick(62);
    chk("busy_start_ready_early", bus.disp_ready, 0);
    tick(1);
    chk("busy_start_ready", bus.disp_ready, 1);
    chk("busy_start_wcnt", bus.word_cnt, 2);
    chk("repeat_count", mon_n, 2);
    chk("repeat_word0", mon_word[0], 9'h011);
    chk("repeat_word1", mon_word[1], 9'h1A5);

    // mid-word reset during the 5th bit
    reset_n = 1'b0;
    mon_clr = 1'b1;
    tick(2);
    reset_n = 1'b1;
    mon_clr = 1'b0;
    tick(1);
    wait_cs_low(50, n);
    chk("mw_cs_fall", n, 2);
    tick(17);
    chk("mw_bit5", bus.lcd_sdi, 1);
    reset_n = 1'b0;
    tick(1);
    chk("mw_cs", bus.lcd_cs, 1);
    chk("mw_sclk", bus.lcd_sclk, 0);
    chk("mw_busy", bus.busy, 0);
    chk("mw_sdi", bus.lcd_sdi, 0);
    mon_clr = 1'b1;
    tick(2);
    mon_clr = 1'b0;
    reset_n = 1'b1;
    tick(1);
    chk("mw_restart_addr", bus.rom_addr, 0);
    wait_ready(300, n);
    chk("mw_done_cycles", n, 84);
    chk("mw_count", mon_n, 2);
    chk("mw_word0", mon_word[0], 9'h011);
    chk("mw_rise0", mon_rise[0], 9);

    // delay entries: 3 ticks, a word, a zero delay, end
    reset_n = 1'b0;
    mon_clr = 1'b1;
    rom[0] = 11'h403;
    rom[1] = 11'h029;
    rom[2] = 11'h400;
    rom[3] = 11'h600;
    tick(2);
    reset_n = 1'b1;
    mon_clr = 1'b0;
    tick(1);
    wait_cs_low(200, n);
    chk("dly_cs_fall", n, 35);
    wait_ready(200, n);
    chk("dly_done_cycles", n, 44);
    chk("dly_wcnt", bus.word_cnt, 1);
    chk("dly_word", mon_word[0], 9'h029);
    chk("dly_addr", bus.rom_addr, 3);

    // no end op: four commands, stops at the last address
    reset_n = 1'b0;
    mon_clr = 1'b1;
    rom[0] = 11'h001;
    rom[1] = 11'h002;
    rom[2] = 11'h003;
    rom[3] = 11'h004;
    tick(2);
    reset_n = 1'b1;
    mon_clr = 1'b0;
    tick(1);
    wait_ready(400, n);
    chk("noend_cycles", n, 164);
    chk("noend_wcnt", bus.word_cnt, 4);
    chk("noend_addr", bus.rom_addr, 3);
    chk("noend_count", mon_n, 4);
    chk("noend_word3", mon_word[3], 9'h004);
    chk("noend_gap", gap_min >= CLK_DIV, 1);
    chk("noend_idle", idle_bad, 0);
    tick(5);
    chk("noend_addr_hold", bus.rom_addr, 3);
    chk("noend_busy", bus.busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
